// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with valid/ready intake and a per-bit clock divider.
// Optional odd-parity trailer bit is enabled by defining SERIALIZER_PARITY_EN.
module bit_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int BIT_DIV    = 1,
  parameter int MSB_FIRST  = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic                  sequence_out,
  output logic                  bit_valid,
  output logic                  busy
);

  localparam int               CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [7:0]       DIV_LAST = 8'(BIT_DIV - 1);

`ifdef SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

  state_t                  state_r;
  logic [DATA_WIDTH-1:0]   shift_r;
  logic [CNT_W-1:0]        bit_cnt_r;
  logic [7:0]              div_cnt_r;
  logic                    last_clk_s;
  logic                    final_s;
  logic                    data_ready_s;
  logic                    xfer_s;
`ifdef SERIALIZER_PARITY_EN
  logic                    parity_r;

  function automatic logic odd_parity(input logic [DATA_WIDTH-1:0] word);
    return ~(^word);
  endfunction
`endif

  // The bit leaving the word first, and the word after that bit is consumed.
  function automatic logic head_bit(input logic [DATA_WIDTH-1:0] word);
    if (MSB_FIRST != 0) begin
      return word[DATA_WIDTH-1];
    end else begin
      return word[0];
    end
  endfunction

  function automatic logic [DATA_WIDTH-1:0] advance(input logic [DATA_WIDTH-1:0] word);
    if (MSB_FIRST != 0) begin
      return {word[DATA_WIDTH-2:0], 1'b0};
    end else begin
      return {1'b0, word[DATA_WIDTH-1:1]};
    end
  endfunction

  // Ready in IDLE and on the last clock of the last bit, so words can stream gap-free.
  always_comb begin
    last_clk_s = (div_cnt_r == DIV_LAST);
    final_s    = 1'b0;
    case (state_r)
`ifdef SERIALIZER_PARITY_EN
      SHIFT:   final_s = 1'b0;
      PARITY:  final_s = last_clk_s;
`else
      SHIFT:   final_s = last_clk_s && (bit_cnt_r == BIT_LAST);
`endif
      default: final_s = 1'b0;
    endcase
    data_ready_s = (state_r == IDLE) || final_s;
    xfer_s       = data_valid && data_ready_s;
  end

  assign data_ready = data_ready_s;

  // Serializer FSM with registered serial outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= IDLE;
      shift_r      <= '0;
      bit_cnt_r    <= '0;
      div_cnt_r    <= 8'd0;
      sequence_out <= 1'b0;
      bit_valid    <= 1'b0;
      busy         <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      parity_r     <= 1'b0;
`endif
    end else if (xfer_s) begin
      // The first bit is presented directly so it appears the cycle after the transfer.
      state_r      <= SHIFT;
      shift_r      <= advance(data_in);
      bit_cnt_r    <= '0;
      div_cnt_r    <= 8'd0;
      sequence_out <= head_bit(data_in);
      bit_valid    <= 1'b1;
      busy         <= 1'b1;
`ifdef SERIALIZER_PARITY_EN
      parity_r     <= odd_parity(data_in);
`endif
    end else begin
      case (state_r)
        IDLE: begin
          sequence_out <= 1'b0;
          bit_valid    <= 1'b0;
          busy         <= 1'b0;
        end
        SHIFT: begin
          if (!last_clk_s) begin
            div_cnt_r <= div_cnt_r + 8'd1;
          end else if (bit_cnt_r != BIT_LAST) begin
            bit_cnt_r    <= bit_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            div_cnt_r    <= 8'd0;
            sequence_out <= head_bit(shift_r);
            shift_r      <= advance(shift_r);
          end else begin
`ifdef SERIALIZER_PARITY_EN
            state_r      <= PARITY;
            div_cnt_r    <= 8'd0;
            sequence_out <= parity_r;
`else
            state_r      <= IDLE;
            sequence_out <= 1'b0;
            bit_valid    <= 1'b0;
            busy         <= 1'b0;
`endif
          end
        end
`ifdef SERIALIZER_PARITY_EN
        PARITY: begin
          if (!last_clk_s) begin
            div_cnt_r <= div_cnt_r + 8'd1;
          end else begin
            state_r      <= IDLE;
            sequence_out <= 1'b0;
            bit_valid    <= 1'b0;
            busy         <= 1'b0;
          end
        end
`endif
        default: begin
          state_r      <= IDLE;
          sequence_out <= 1'b0;
          bit_valid    <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 The block SHALL have the parameter DATA_WIDTH, default 8: width of each parallel word, legal range 2..32.
REQ-002 The block SHALL have the parameter BIT_DIV, default 1: clocks each serial bit is held, legal range 1..255.
REQ-003 The block SHALL have the parameter MSB_FIRST, default 1: 1 = MSB shifted first, 0 = LSB shifted first.
REQ-004 The block SHALL have the port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have the port reset, input, 1 bit: reset is synchronous and active-high.
REQ-006 The block SHALL have the port data_in, input, DATA_WIDTH bits: parallel word to serialize.
REQ-007 The block SHALL have the port data_valid, input, 1 bit: data_in holds a word offered for transfer.
REQ-008 The block SHALL have the port data_ready, output, 1 bit: the block accepts a word on this edge.
REQ-009 The block SHALL have the port sequence_out, output, 1 bit: serial bit stream feeding the downstream sequence detector input.
REQ-010 The block SHALL have the port bit_valid, output, 1 bit: sequence_out carries a word or parity bit.
REQ-011 The block SHALL have the port busy, output, 1 bit: a word is in flight (state not IDLE).

Function
REQ-012 Handshake: a word SHALL transfer on a rising edge where data_valid=1 and data_ready=1; data_valid with data_ready=0 SHALL be ignored, and upstream holds data_in.
REQ-013 FSM states SHALL be IDLE, SHIFT and PARITY (PARITY only with the macro in REQ-024); any unencoded state SHALL go to IDLE.
REQ-014 IDLE: data_ready=1, sequence_out=0, bit_valid=0, busy=0; on transfer, load the shift register, clear bit and divider counters, go to SHIFT.
REQ-015 Latency: the first bit of an accepted word SHALL appear on sequence_out, with bit_valid=1, the cycle immediately after the transfer edge.
REQ-016 SHIFT: each bit SHALL be held exactly BIT_DIV clocks; bit order per MSB_FIRST; bit_valid=1, busy=1 throughout.
REQ-017 Outputs sequence_out, bit_valid and busy SHALL be registered; data_ready SHALL be combinational from state and counters only, never from data_valid.
REQ-018 data_ready SHALL also be 1 during the final clock of the final bit of a word (final data bit, or parity bit when enabled), so back-to-back words stream with no gap cycle.
REQ-019 At the end of the final bit: if a transfer occurs, reload and stay in SHIFT; otherwise go to IDLE and drive sequence_out=0, bit_valid=0.
REQ-020 Bit counter width SHALL be clog2(DATA_WIDTH); divider counter 8 bits; both wrap only through explicit reload, never modulo overflow.

Reset
REQ-021 While reset=1 at a rising edge, the next state SHALL be IDLE: sequence_out=0, bit_valid=0, busy=0; data_ready is 1 the cycle after reset.
REQ-022 Reset mid-word SHALL abandon the word with no further bits emitted; a transfer coinciding with reset SHALL be discarded.
REQ-023 Reset SHALL take priority over every other event in the same cycle.

Configuration
REQ-024 With SERIALIZER_PARITY_EN defined, after the last data bit the block SHALL enter PARITY and emit one odd-parity bit (total ones including parity is odd), held BIT_DIV clocks, with bit_valid=1.
REQ-025 Without SERIALIZER_PARITY_EN, the PARITY state and parity logic SHALL be absent, and SHIFT SHALL end directly after the last data bit.

Verification
REQ-026 DATA_WIDTH=8, BIT_DIV=1, MSB_FIRST=1, transfer 8'hB6 -> sequence_out 1,0,1,1,0,1,1,0 on cycles 1..8 after transfer, bit_valid=1 for exactly those 8 cycles, then 0.
REQ-027 MSB_FIRST=0, 8'hB6 -> sequence_out 0,1,1,0,1,1,0,1.
REQ-028 Back-to-back 8'hB0 then 8'h0F, data_valid held high -> 16 contiguous bit_valid cycles, stream 1011000000001111, second transfer on the 8th bit cycle.
REQ-029 BIT_DIV=3, 8'h80 -> 3 cycles of 1 then 21 cycles of 0 with bit_valid=1, 24 total.
REQ-030 Reset asserted during the 4th bit of 8'hFF -> next cycle sequence_out=0, bit_valid=0, busy=0, data_ready=1.
REQ-031 With SERIALIZER_PARITY_EN, 8'hB6 (five ones) -> 9 bit cycles, 9th bit = 0; 8'h03 -> 9th bit = 1.
